mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-port unified program/data memory between the CPU's instruction-fetch path and its load/store path. Each requester uses a req/ack handshake. The arbiter grants one requester at a time, drives the memory port for that requester, waits out memory wait states or a bus timeout, and returns read data with a one-cycle acknowledge. It sits between the CPU core (PC/fetch logic and the decoder's load/store control: `memWE`, `dAddrSel`) and the memory.

## Interface
Parameters:
- `AW`, 16: address width.
- `DW`, 16: data width.
- `TMO`, 15: timeout in BUSY cycles. 0 disables the timeout. Maximum 255.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_req`  in  1  fetch request; held with `i_addr` until `i_ack`.
- `i_addr`  in  AW  fetch address.
- `i_ack`  out  1  one-cycle fetch-complete pulse.
- `d_req`  in  1  data request; held with the payload until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  store data.
- `d_ack`  out  1  one-cycle data-complete pulse.
- `rdata`  out  DW  read data for the completed read; valid while ack is high.
- `err`  out  1  transfer timed out; valid while ack is high.
- `busy`  out  1  high in BUSY and ACK.
- `mem_en`  out  1  memory access active.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data; valid when `mem_ready` is high.
- `mem_ready`  in  1  memory completes the current access.

## Operation
- State machine:
  - IDLE: no requests pending, or choosing which request to grant.
  - BUSY: memory access in progress.
  - ACK: completion reported to the owner.
- IDLE: when either request is high, grant one requester, latch its address, write data and we into internal registers, record the owner, clear the timeout counter, and go to BUSY. With no request, stay in IDLE.
- Arbitration when both requests are high in the same IDLE cycle: data wins (default; see Configuration).
- BUSY:
  - `mem_en` = 1, driven from the latched registers.
  - `mem_we` = latched we; always 0 for fetch.
  - `mem_wdata` = latched data.
  - When `mem_ready` = 1: capture `mem_rdata` into `rdata` (reads only; stores leave `rdata` unchanged), set `err` = 0, go to ACK.
  - When `mem_ready` = 0 and `TMO` != 0: increment the 8-bit counter. On the cycle the counter reaches `TMO`, go to ACK with `err` = 1 and `rdata` = all ones. The counter does not wrap.
- ACK:
  - Assert exactly one of `i_ack`/`d_ack` (the owner's) for one cycle.
  - `mem_en` = 0.
  - No new grant is made in this state.
  - Next state is IDLE.
- Requester rules: drop req in the cycle ack is seen, or hold it high to request again. A req still high in the following IDLE cycle is treated as a new request.
- `mem_addr`, `mem_wdata` and `mem_we` hold their last latched values in IDLE and ACK. `mem_we` is gated to 0 outside BUSY.
- A change on an un-granted requester's inputs has no effect until that requester is granted.

## Timing
- Reset values:
  - State = IDLE.
  - Outputs: `i_ack` = `d_ack` = `err` = `busy` = `mem_en` = `mem_we` = 0; `rdata` = 0; `mem_addr` = 0; `mem_wdata` = 0.
  - Internal: timeout counter = 0; round-robin last-served = fetch.
- Reset asserted mid-transfer: all of the above takes effect immediately (asynchronously). `mem_en` drops without waiting for the clock. No ack is produced for the aborted transfer.
- Latency (req sampled high in IDLE at cycle 0):
  - BUSY in cycle 1.
  - With `mem_ready` high in cycle 1 + W (W wait states), ack is in cycle 2 + W.
  - Minimum req-to-ack is 2 cycles. Back-to-back transfers from a held req take one transfer per 3 cycles.
- Timeout: with `mem_ready` stuck at 0, ack + `err` appears `TMO` + 1 cycles after BUSY entry.
- `mem_ready` is ignored outside BUSY.
- All outputs are registered or decoded from state only; there is no combinational path from req to the `mem_*` outputs.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. When both requests are pending in IDLE, grant the requester not served last. The last-served register updates on each grant. After reset, data wins the first contention.
- Not defined: fixed priority, data over fetch. The last-served register is not implemented.

## Test plan
- Single fetch, `i_addr` = 0x0010, `mem_ready` tied high, `mem_rdata` = 0x1234 → `mem_en` high 1 cycle, `i_ack` 2 cycles after req, `rdata` = 0x1234, `err` = 0.
- Store with `d_addr` = 0x0200, `d_wdata` = 0xBEEF, 3 wait states → `mem_we` high 4 cycles, `d_ack` at cycle 5, `rdata` unchanged.
- `i_req` and `d_req` both held high for 4 transfers → default build grants D, D, D, D. With `MEM_ARB_RR_EN`, grants alternate D, I, D, I, and each ack goes to the correct owner.
- `TMO` = 15, `mem_ready` stuck low → ack with `err` = 1 and `rdata` = 0xFFFF, 16 cycles after BUSY entry. The arbiter then returns to IDLE and grants the next request.
- `rst_n` pulsed low during BUSY with 2 of 5 wait states elapsed → `mem_en` drops immediately, no ack, state IDLE. A new request completes normally after reset is released.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch and load/store requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_arbiter #(
    parameter int unsigned AW  = 16,
    parameter int unsigned DW  = 16,
    parameter int unsigned TMO = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);
    localparam int unsigned   CW      = 8;
    localparam logic [CW-1:0] TMO_CNT = CW'(TMO);
    localparam bit            TMO_EN  = (TMO != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic          owner_d, owner_d_nx;
    logic          we_lat, we_lat_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          i_ack_nx, d_ack_nx, err_nx, busy_nx, mem_en_nx, mem_we_nx;
    logic [DW-1:0] rdata_nx, mem_wdata_nx;
    logic [AW-1:0] mem_addr_nx;
    logic          grant_d;

`ifdef MEM_ARB_RR_EN
    logic last_d, last_d_nx;
    // On contention, grant the requester that was not served last.
    assign grant_d = d_req & (~i_req | ~last_d);
`else
    assign grant_d = d_req;
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_nx     = state;
        owner_d_nx   = owner_d;
        we_lat_nx    = we_lat;
        cnt_nx       = cnt;
        i_ack_nx     = 1'b0;
        d_ack_nx     = 1'b0;
        err_nx       = err;
        busy_nx      = busy;
        mem_en_nx    = mem_en;
        mem_we_nx    = mem_we;
        rdata_nx     = rdata;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
`ifdef MEM_ARB_RR_EN
        last_d_nx    = last_d;
`endif
        unique case (state)
            S_IDLE: begin
                if (i_req || d_req) begin
                    state_nx     = S_BUSY;
                    owner_d_nx   = grant_d;
                    we_lat_nx    = grant_d & d_we;
                    cnt_nx       = '0;
                    busy_nx      = 1'b1;
                    mem_en_nx    = 1'b1;
                    mem_we_nx    = grant_d & d_we;
                    mem_addr_nx  = grant_d ? d_addr : i_addr;
                    mem_wdata_nx = grant_d ? d_wdata : mem_wdata;
                    err_nx       = 1'b0;
`ifdef MEM_ARB_RR_EN
                    last_d_nx    = grant_d;
`endif
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    state_nx  = S_ACK;
                    mem_en_nx = 1'b0;
                    mem_we_nx = 1'b0;
                    err_nx    = 1'b0;
                    i_ack_nx  = ~owner_d;
                    d_ack_nx  = owner_d;
                    if (!we_lat) rdata_nx = mem_rdata;
                end else if (TMO_EN) begin
                    // Counter stops at TMO, so it never wraps.
                    if (cnt == TMO_CNT) begin
                        state_nx  = S_ACK;
                        mem_en_nx = 1'b0;
                        mem_we_nx = 1'b0;
                        err_nx    = 1'b1;
                        rdata_nx  = '1;
                        i_ack_nx  = ~owner_d;
                        d_ack_nx  = owner_d;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            S_ACK: begin
                state_nx = S_IDLE;
                busy_nx  = 1'b0;
                err_nx   = 1'b0;
            end
            default: begin
                state_nx  = S_IDLE;
                busy_nx   = 1'b0;
                mem_en_nx = 1'b0;
                mem_we_nx = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            owner_d   <= 1'b0;
            we_lat    <= 1'b0;
            cnt       <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_ARB_RR_EN
            last_d    <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            owner_d   <= owner_d_nx;
            we_lat    <= we_lat_nx;
            cnt       <= cnt_nx;
            i_ack     <= i_ack_nx;
            d_ack     <= d_ack_nx;
            err       <= err_nx;
            busy      <= busy_nx;
            mem_en    <= mem_en_nx;
            mem_we    <= mem_we_nx;
            rdata     <= rdata_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
`ifdef MEM_ARB_RR_EN
            last_d    <= last_d_nx;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed plan cases plus randomized traffic
// checked against a transaction-level model of grant order, latency and memory contents.
module tb_mem_arbiter;
    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned TMO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, d_req, d_we, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          i_ack, d_ack, err, busy, mem_en, mem_we;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] resp_mem [256];
    logic [DW-1:0] ref_mem  [256];
    logic [DW-1:0] exp_rdata;
    logic [AW-1:0] exp_maddr;
    bit            last_d;
    bit            obs_d;
    logic [3:0]    pat;
    logic [3:0]    exp_pat;

    mem_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .err(err), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Requesters that are not asking may change their inputs at will.
    task automatic scramble_idle_side();
        if (!i_req) i_addr = AW'($urandom);
        if (!d_req) begin
            d_addr  = AW'($urandom);
            d_wdata = DW'($urandom);
            d_we    = 1'($urandom);
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_ctl", 32'({busy, mem_en, mem_we, i_ack, d_ack}), 32'(0));
        chk("idle_addr_hold", 32'(mem_addr), 32'(exp_maddr));
        mem_ready = 1'($urandom);
        mem_rdata = DW'($urandom);
        scramble_idle_side();
    endtask

    // One granted transfer; requests are already driven in the current IDLE cycle.
    // policy: 0 random, 1 winner holds req, 2 winner drops req.
    task automatic do_grant(input int w, input int policy);
        bit            win_d, we, tmo, hold;
        int            e;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            win_d = !last_d;
`else
            win_d = 1'b1;
`endif
        end else begin
            win_d = d_req;
        end
        a   = win_d ? d_addr : i_addr;
        we  = win_d && d_we;
        wd  = d_wdata;
        tmo = (TMO != 0) && (w > int'(TMO));
        e   = tmo ? int'(TMO) : w;
        for (int k = 1; k <= e + 1; k++) begin
            @(negedge clk);
            chk("busy_ctl", 32'({busy, mem_en, mem_we, i_ack, d_ack}),
                32'({1'b1, 1'b1, we, 1'b0, 1'b0}));
            chk("busy_addr", 32'(mem_addr), 32'(a));
            if (we) chk("busy_wdata", 32'(mem_wdata), 32'(wd));
            scramble_idle_side();
            mem_ready = !tmo && (k == e + 1);
            if (mem_ready) begin
                mem_rdata = resp_mem[mem_addr[7:0]];
                if (mem_we) resp_mem[mem_addr[7:0]] = mem_wdata;
            end else begin
                mem_rdata = DW'($urandom);
            end
        end
        @(negedge clk);
        chk("ack_ctl", 32'({busy, mem_en, mem_we, i_ack, d_ack}),
            32'({1'b1, 1'b0, 1'b0, !win_d, win_d}));
        if (tmo)      exp_rdata = '1;
        else if (!we) exp_rdata = ref_mem[a[7:0]];
        else          ref_mem[a[7:0]] = wd;
        chk("ack_rdata", 32'(rdata), 32'(exp_rdata));
        chk("ack_err", 32'(err), 32'(tmo));
        chk("ack_addr_hold", 32'(mem_addr), 32'(a));
        exp_maddr = a;
        last_d    = win_d;
        obs_d     = d_ack;
        mem_ready = 1'($urandom);
        mem_rdata = DW'($urandom);
        hold = (policy == 1) || (policy == 0 && $urandom_range(0, 3) == 0);
        if (win_d) begin
            if (hold) begin
                d_addr  = AW'($urandom);
                d_wdata = DW'($urandom);
                d_we    = 1'($urandom);
            end else d_req = 1'b0;
        end else begin
            if (hold) i_addr = AW'($urandom);
            else      i_req  = 1'b0;
        end
    endtask

    function automatic int pick_w();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 30;
        if (r == 1) return int'(TMO);
        return $urandom_range(0, 4);
    endfunction

    initial begin
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            resp_mem[i] = DW'($urandom);
            ref_mem[i]  = resp_mem[i];
        end
        resp_mem[8'h10] = 16'h1234;
        ref_mem[8'h10]  = 16'h1234;
        exp_rdata = '0; exp_maddr = '0; last_d = 1'b0; pat = '0;

        repeat (3) @(negedge clk);
        chk("reset_ctl", 32'({busy, mem_en, mem_we, i_ack, d_ack, err}), 32'(0));
        chk("reset_rdata", 32'(rdata), 32'(0));
        chk("reset_maddr", 32'(mem_addr), 32'(0));
        chk("reset_mwdata", 32'(mem_wdata), 32'(0));
        rst_n = 1'b1;

        // Store, 3 wait states.
        idle_check();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
        do_grant(3, 2);

        // Fetch, no wait states.
        idle_check();
        i_req = 1'b1; i_addr = 16'h0010;
        do_grant(0, 2);
        chk("fetch_rdata", 32'(rdata), 32'h1234);

        // Both requests held for four transfers.
        idle_check();
        i_req = 1'b1; i_addr = AW'($urandom);
        d_req = 1'b1; d_we = 1'b0; d_addr = AW'($urandom);
        for (int n = 0; n < 4; n++) begin
            if (n != 0) idle_check();
            do_grant($urandom_range(0, 2), 1);
            pat = {pat[2:0], obs_d};
        end
`ifdef MEM_ARB_RR_EN
        exp_pat = 4'b1010;
`else
        exp_pat = 4'b1111;
`endif
        chk("contention_order", 32'(pat), 32'(exp_pat));
        idle_check();
        i_req = 1'b0; d_req = 1'b0;

        // Timeout, then a normal transfer.
        idle_check();
        i_req = 1'b1; i_addr = AW'($urandom);
        do_grant(40, 2);
        idle_check();
        d_req = 1'b1; d_we = 1'b1; d_addr = AW'($urandom); d_wdata = DW'($urandom);
        do_grant(1, 2);

        // Reset during BUSY with two of five wait states elapsed.
        idle_check();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0033;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            mem_ready = 1'b0;
        end
        chk("pre_reset_en", 32'(mem_en), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ctl", 32'({busy, mem_en, mem_we, i_ack, d_ack, err}), 32'(0));
        chk("async_reset_rdata", 32'(rdata), 32'(0));
        chk("async_reset_maddr", 32'(mem_addr), 32'(0));
        d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = '0; exp_maddr = '0; last_d = 1'b0;

        idle_check();
        i_req = 1'b1; i_addr = 16'h0010;
        do_grant(2, 2);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            idle_check();
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req  = 1'b1;
                i_addr = AW'($urandom);
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom);
                d_addr  = AW'($urandom);
                d_wdata = DW'($urandom);
            end
            if (i_req || d_req) do_grant(pick_w(), 0);
        end
        idle_check();
        i_req = 1'b0; d_req = 1'b0;
        idle_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
